// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider, one quotient bit per clock.
// Operands are captured at start; the result is held until start_in drops.
//   clk, rst         : clock (rising edge), asynchronous active-high reset
//   signed_div_in    : 1 = DIV (two's complement), 0 = DIVU
//   opdata1_in       : dividend
//   opdata2_in       : divisor
//   start_in         : request, held high until the result is consumed
//   annul_in         : abort an in-flight operation
//   result_out       : {remainder -> HI, quotient -> LO}
//   ready_out        : result_out valid
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_in,
    input  logic [WIDTH-1:0]     opdata1_in,
    input  logic [WIDTH-1:0]     opdata2_in,
    input  logic                 start_in,
    input  logic                 annul_in,
    output logic [2*WIDTH-1:0]   result_out,
    output logic                 ready_out
);

    localparam int unsigned CNT_W  = $clog2(WIDTH) + 1;
    localparam int unsigned WORK_W = 2 * WIDTH + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BYZERO = 2'd1;
    localparam logic [1:0] S_ON     = 2'd2;
    localparam logic [1:0] S_END    = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WORK_W-1:0]    work_q, work_d;
    logic [WIDTH-1:0]     divisor_q, divisor_d;
    logic                 sgn_q, sgn_d;
    logic                 dend_neg_q, dend_neg_d;
    logic                 dsor_neg_q, dsor_neg_d;
    logic                 ready_q, ready_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    // Iteration datapath: shift, then trial-subtract from the upper WIDTH+1 bits
    logic [WORK_W-1:0]    work_sh;
    logic [WIDTH+1:0]     diff;
    logic [WIDTH-1:0]     quo_fix, rem_fix;
    logic                 in_dend_neg, in_dsor_neg;
    logic [WIDTH-1:0]     in_dend_abs, in_dsor_abs;

    always_comb begin
        work_sh = work_q << 1;
        diff    = {1'b0, work_sh[2*WIDTH:WIDTH]} - {2'b0, divisor_q};

        // Sign fix: quotient sign is the XOR of operand signs, remainder follows the dividend
        quo_fix = (sgn_q && (dend_neg_q ^ dsor_neg_q)) ? (WIDTH'(0) - work_q[WIDTH-1:0])
                                                      : work_q[WIDTH-1:0];
        rem_fix = (sgn_q && dend_neg_q) ? (WIDTH'(0) - work_q[2*WIDTH-1:WIDTH])
                                        : work_q[2*WIDTH-1:WIDTH];

        in_dend_neg = signed_div_in & opdata1_in[WIDTH-1];
        in_dsor_neg = signed_div_in & opdata2_in[WIDTH-1];
        in_dend_abs = in_dend_neg ? (WIDTH'(0) - opdata1_in) : opdata1_in;
        in_dsor_abs = in_dsor_neg ? (WIDTH'(0) - opdata2_in) : opdata2_in;
    end

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        divisor_d  = divisor_q;
        sgn_d      = sgn_q;
        dend_neg_d = dend_neg_q;
        dsor_neg_d = dsor_neg_q;
        ready_d    = ready_q;
        result_d   = result_q;

        case (state_q)
            S_IDLE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (start_in && !annul_in) begin
                    if (opdata2_in == '0) begin
                        state_d = S_BYZERO;
                    end else begin
                        state_d    = S_ON;
                        cnt_d      = '0;
                        work_d     = {(WIDTH + 1)'(0), in_dend_abs};
                        divisor_d  = in_dsor_abs;
                        sgn_d      = signed_div_in;
                        dend_neg_d = in_dend_neg;
                        dsor_neg_d = in_dsor_neg;
                    end
                end
            end
            S_BYZERO: begin
                if (annul_in) begin
                    state_d  = S_IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else begin
                    state_d  = S_END;
                    ready_d  = 1'b1;
                    result_d = '0;
                end
            end
            S_ON: begin
                if (annul_in) begin
                    state_d  = S_IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else if (cnt_q != CNT_W'(WIDTH)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (!diff[WIDTH+1]) begin
                        work_d = {diff[WIDTH:0], work_sh[WIDTH-1:0] | WIDTH'(1)};
                    end else begin
                        work_d = work_sh;
                    end
                end else begin
                    state_d  = S_END;
                    ready_d  = 1'b1;
                    result_d = {rem_fix, quo_fix};
                end
            end
            S_END: begin
                if (!start_in) begin
                    state_d  = S_IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end
            default: begin
                state_d  = S_IDLE;
                ready_d  = 1'b0;
                result_d = '0;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            work_q     <= '0;
            divisor_q  <= '0;
            sgn_q      <= 1'b0;
            dend_neg_q <= 1'b0;
            dsor_neg_q <= 1'b0;
            ready_q    <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            divisor_q  <= divisor_d;
            sgn_q      <= sgn_d;
            dend_neg_q <= dend_neg_d;
            dsor_neg_q <= dsor_neg_d;
            ready_q    <= ready_d;
            result_q   <= result_d;
        end
    end

    assign ready_out  = ready_q;
    assign result_out = result_q;

endmodule
